// File: rtl/bus_cycle_ack.sv
// bus_cycle_ack: 68000 bus-cycle tracker, DTACK/BERR terminator and DRAM refresh request timer.
// Ports:
//   clk_i, rst_i             CPU clock, asynchronous active-high reset
//   nas_i                    CPU address strobe (active low)
//   ramcs_i/romcs_i/iocs_i   region selects, valid while nas_i is low
//   ramready_i               DRAM controller ready (RAM-region handshake)
//   refack_i                 one-clock pulse: controller started a refresh
//   bact_o, bactr_o          registered !nAS and its one-clock delay
//   ndtack_o, nberr_o        cycle terminators (active low)
//   refreq_o, refurg_o       refresh request / urgency to the DRAM controller
module bus_cycle_ack #(
    parameter int ROM_WS     = 2,
    parameter int IO_WS      = 4,
    parameter int TIMEOUT    = 255,
    parameter int REF_PERIOD = 250,
    parameter int REF_URG    = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic nas_i,
    input  logic ramcs_i,
    input  logic romcs_i,
    input  logic iocs_i,
    input  logic ramready_i,
    input  logic refack_i,
    output logic bact_o,
    output logic bactr_o,
    output logic ndtack_o,
    output logic nberr_o,
    output logic refreq_o,
    output logic refurg_o
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    typedef enum logic [1:0] {R_RAM, R_ROM, R_IO, R_NONE} region_t;

    state_t     state_q, state_d;
    region_t    region_q, region_d;
    logic       bact_q, bactr_q, armed_q;
    logic [7:0] cnt_q, cnt_d;
    logic       ndtack_q, ndtack_d, nberr_q, nberr_d;
    logic       start, hit;

    logic [9:0] tmr_q, tmr_d;
    logic [7:0] ucnt_q, ucnt_d;
    logic [1:0] miss_q, miss_d, miss_a;
    logic       req_q, req_d, req_a, urg_q, urg_d;
    logic       tick, ack, clr;

    // A cycle already in flight when reset releases must not be acknowledged,
    // so starts are only honoured once /AS has been seen high after reset.
    assign start = bact_q && !bactr_q && armed_q;

    assign hit = (region_q == R_RAM) ? (ramready_i && bactr_q) :
                 (region_q == R_ROM) ? (cnt_q == 8'(ROM_WS - 1)) :
                 (region_q == R_IO)  ? (cnt_q == 8'(IO_WS - 1)) :
                                       (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? WAIT : IDLE;
            WAIT:    state_d = !bact_q ? IDLE : hit ? ACK : WAIT;
            ACK:     state_d = !bact_q ? IDLE : ACK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        region_d = region_q;
        cnt_d    = cnt_q;
        ndtack_d = ndtack_q;
        nberr_d  = nberr_q;
        if (state_q == IDLE && start) begin
            region_d = ramcs_i ? R_RAM : romcs_i ? R_ROM : iocs_i ? R_IO : R_NONE;
            cnt_d    = '0;
        end
        if (state_q == WAIT && bact_q) begin
            cnt_d = cnt_q + 8'd1;
            if (hit) begin
                ndtack_d = region_q == R_NONE;
                nberr_d  = region_q != R_NONE;
            end
        end
        if (state_q == ACK && !bact_q) begin
            ndtack_d = 1'b1;
            nberr_d  = 1'b1;
        end
    end

    // Refresh: a pending ack is applied before a coincident tick so a fresh
    // request is re-raised rather than lost.
    assign tick   = tmr_q == '0;
    assign tmr_d  = tick ? 10'(REF_PERIOD - 1) : tmr_q - 10'd1;
    assign ack    = refack_i && req_q;
    assign req_a  = ack ? (miss_q != 2'd0) : req_q;
    assign miss_a = (ack && miss_q != 2'd0) ? miss_q - 2'd1 : miss_q;
    assign req_d  = req_a || tick;
    assign miss_d = (tick && req_a && miss_a != 2'd3) ? miss_a + 2'd1 : miss_a;
    assign clr    = ack || (tick && !req_a);
    assign ucnt_d = clr ? 8'd0 : ((req_q && ucnt_q != 8'hff) ? ucnt_q + 8'd1 : ucnt_q);
    assign urg_d  = req_d && (((clr ? 8'd0 : ucnt_q) >= 8'(REF_URG - 1)) || miss_d != 2'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bact_q   <= 1'b0;
            bactr_q  <= 1'b0;
            armed_q  <= 1'b0;
            region_q <= R_NONE;
            cnt_q    <= '0;
            ndtack_q <= 1'b1;
            nberr_q  <= 1'b1;
            tmr_q    <= 10'(REF_PERIOD - 1);
            ucnt_q   <= '0;
            miss_q   <= '0;
            req_q    <= 1'b0;
            urg_q    <= 1'b0;
        end else begin
            bact_q   <= !nas_i;
            bactr_q  <= bact_q;
            armed_q  <= armed_q || nas_i;
            region_q <= region_d;
            cnt_q    <= cnt_d;
            ndtack_q <= ndtack_d;
            nberr_q  <= nberr_d;
            tmr_q    <= tmr_d;
            ucnt_q   <= ucnt_d;
            miss_q   <= miss_d;
            req_q    <= req_d;
            urg_q    <= urg_d;
        end
    end

    assign bact_o   = bact_q;
    assign bactr_o  = bactr_q;
    assign ndtack_o = ndtack_q;
    assign nberr_o  = nberr_q;
    assign refreq_o = req_q;
    assign refurg_o = urg_q;
endmodule

// File: tb/tb_bus_cycle_ack.sv
// tb_bus_cycle_ack: scoreboard bench for bus_cycle_ack.
module tb_bus_cycle_ack;
    logic clk = 1'b0, rst = 1'b1, nas = 1'b1;
    logic ramcs = 1'b0, romcs = 1'b0, iocs = 1'b0, ramready = 1'b0, refack = 1'b0;
    logic bact, bactr, ndtack, nberr, refreq, refurg;
    int errors = 0, checks = 0;

    typedef struct {int kind; int fall; int rise;} ev_t;
    typedef struct {logic req; logic urg;} ref_t;
    ev_t  exp_q[$];
    ref_t ref_q[$];

    bus_cycle_ack #(
        .ROM_WS(2), .IO_WS(4), .TIMEOUT(8), .REF_PERIOD(16), .REF_URG(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .nas_i(nas),
        .ramcs_i(ramcs), .romcs_i(romcs), .iocs_i(iocs),
        .ramready_i(ramready), .refack_i(refack),
        .bact_o(bact), .bactr_o(bactr), .ndtack_o(ndtack), .nberr_o(nberr),
        .refreq_o(refreq), .refurg_o(refurg)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] lo_mask(input int n);
        return (40'd1 << n) - 40'd1;
    endfunction

    task automatic set_sel(input logic [2:0] sel, input logic on);
        {ramcs, romcs, iocs} = on ? sel : 3'b000;
    endtask

    task automatic push_ev(input int kind, input int fall, input int rise);
        exp_q.push_back('{kind, fall, rise});
    endtask

    // kind: 1 = nDTACK, 2 = nBERR, 3 = both; lo[k] = /AS driven low after posedge k
    task automatic bus_run(input string name, input logic [2:0] sel, input logic [39:0] lo,
                           input int ready_after);
        int   n_exp, n_obs, kobs;
        logic active, have, wr;
        ev_t  cur;
        n_exp  = exp_q.size();
        n_obs  = 0;
        active = 1'b0;
        have   = 1'b0;
        cur    = '{0, 0, 0};
        nas    = !lo[0];
        set_sel(sel, lo[0]);
        ramready = ready_after == 0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            wr = 1'b0;
            if (k >= 2) wr = lo[k-2];
            checks += 2;
            if (bact !== lo[k-1]) begin
                errors++;
                $display("FAIL %s bact k=%0d got %b want %b", name, k, bact, lo[k-1]);
            end
            if (bactr !== wr) begin
                errors++;
                $display("FAIL %s bactr k=%0d got %b want %b", name, k, bactr, wr);
            end
            if (!active && (!ndtack || !nberr)) begin
                active = 1'b1;
                n_obs++;
                kobs = (!ndtack && !nberr) ? 3 : !ndtack ? 1 : 2;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s unexpected strobe kind=%0d at k=%0d, want none", name, kobs, k);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                    checks += 2;
                    if (kobs != cur.kind) begin
                        errors++;
                        $display("FAIL %s strobe kind got %0d want %0d", name, kobs, cur.kind);
                    end
                    if (k != cur.fall) begin
                        errors++;
                        $display("FAIL %s strobe fall got k=%0d want k=%0d", name, k, cur.fall);
                    end
                end
            end else if (active && ndtack && nberr) begin
                active = 1'b0;
                if (have) begin
                    checks++;
                    if (k != cur.rise) begin
                        errors++;
                        $display("FAIL %s strobe rise got k=%0d want k=%0d", name, k, cur.rise);
                    end
                end
            end
            nas = !lo[k];
            set_sel(sel, lo[k]);
            if (k == ready_after) ramready = 1'b1;
        end
        checks += 2;
        if (n_obs != n_exp) begin
            errors++;
            $display("FAIL %s strobe count got %0d want %0d", name, n_obs, n_exp);
        end
        if (active) begin
            errors++;
            $display("FAIL %s strobe still asserted at end got 1 want 0", name);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        checks += 6;
        if (bact !== 1'b0)   begin errors++; $display("FAIL reset bact got %b want 0", bact); end
        if (bactr !== 1'b0)  begin errors++; $display("FAIL reset bactr got %b want 0", bactr); end
        if (ndtack !== 1'b1) begin errors++; $display("FAIL reset ndtack got %b want 1", ndtack); end
        if (nberr !== 1'b1)  begin errors++; $display("FAIL reset nberr got %b want 1", nberr); end
        if (refreq !== 1'b0) begin errors++; $display("FAIL reset refreq got %b want 0", refreq); end
        if (refurg !== 1'b0) begin errors++; $display("FAIL reset refurg got %b want 0", refurg); end
    endtask

    task automatic test_ram();
        push_ev(1, 3, 8);
        bus_run("ram", 3'b100, lo_mask(6), 0);
        push_ev(1, 7, 12);
        bus_run("ram_wait", 3'b100, lo_mask(10), 6);
    endtask

    task automatic test_rom_io();
        push_ev(1, 4, 8);
        bus_run("rom", 3'b010, lo_mask(6), 0);
        push_ev(1, 6, 10);
        bus_run("io", 3'b001, lo_mask(8), 0);
    endtask

    task automatic test_timeout();
        push_ev(2, 10, 14);
        bus_run("none", 3'b000, lo_mask(12), 0);
        bus_run("abort", 3'b000, lo_mask(6), 0);
    endtask

    task automatic test_back_to_back();
        push_ev(1, 3, 6);
        push_ev(1, 8, 11);
        bus_run("b2b", 3'b100, lo_mask(4) | (lo_mask(4) << 5), 0);
    endtask

    function automatic logic exp_req(input int k);
        return (k >= 16 && k <= 45) || k >= 48;
    endfunction

    function automatic logic exp_urg(input int k);
        return (k >= 20 && k <= 39) || (k >= 44 && k <= 45) || (k >= 52 && k <= 63) || k >= 68;
    endfunction

    function automatic logic ack_at(input int k);
        return k == 10 || k == 40 || k == 46 || k == 64;
    endfunction

    task automatic test_refresh();
        ref_t e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) ref_q.push_back('{exp_req(k), exp_urg(k)});
        refack = ack_at(1);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            e = ref_q.pop_front();
            checks += 2;
            if (refreq !== e.req) begin
                errors++;
                $display("FAIL refresh refreq k=%0d got %b want %b", k, refreq, e.req);
            end
            if (refurg !== e.urg) begin
                errors++;
                $display("FAIL refresh refurg k=%0d got %b want %b", k, refurg, e.urg);
            end
            refack = ack_at(k + 1);
        end
        refack = 1'b0;
    endtask

    task automatic test_reset_midcycle();
        int n;
        nas = 1'b0;
        set_sel(3'b100, 1'b1);
        ramready = 1'b1;
        repeat (3) @(negedge clk);
        checks += 2;
        if (ndtack !== 1'b0) begin errors++; $display("FAIL midrst pre ndtack got %b want 0", ndtack); end
        if (refreq !== 1'b1) begin errors++; $display("FAIL midrst pre refreq got %b want 1", refreq); end
        #1 rst = 1'b1;
        #1;
        checks += 5;
        if (ndtack !== 1'b1) begin errors++; $display("FAIL midrst ndtack got %b want 1", ndtack); end
        if (bact !== 1'b0)   begin errors++; $display("FAIL midrst bact got %b want 0", bact); end
        if (bactr !== 1'b0)  begin errors++; $display("FAIL midrst bactr got %b want 0", bactr); end
        if (refreq !== 1'b0) begin errors++; $display("FAIL midrst refreq got %b want 0", refreq); end
        if (refurg !== 1'b0) begin errors++; $display("FAIL midrst refurg got %b want 0", refurg); end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!ndtack || !nberr) n++;
        end
        checks += 2;
        if (n != 0)        begin errors++; $display("FAIL midrst strobe clocks got %0d want 0", n); end
        if (bact !== 1'b1) begin errors++; $display("FAIL midrst bact held got %b want 1", bact); end
        nas = 1'b1;
        set_sel(3'b000, 1'b0);
        repeat (2) @(negedge clk);
        push_ev(1, 3, 8);
        bus_run("ram_after_rst", 3'b100, lo_mask(6), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_ram();
        test_rom_io();
        test_timeout();
        test_back_to_back();
        test_refresh();
        test_reset_midcycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
